// File: rtl/dma_pkg.sv
// Shared DMA types: transfer mode and the descriptor handed to the DDR bank sequencer.
package dma_pkg;

  localparam int DMA_ADDR_W = 64;

  typedef enum logic [1:0] {
    DDR_TO_HOST  = 2'd0,
    HOST_TO_DDR  = 2'd1,
    HOST_TO_HOST = 2'd2,
    DDR_TO_DDR   = 2'd3
  } t_dma_mode;

  typedef struct packed {
    t_dma_mode               mode;
    logic [DMA_ADDR_W-1:0]   src_addr;
    logic [DMA_ADDR_W-1:0]   dest_addr;
  } t_dma_descriptor;

endpackage

// File: rtl/dma_ddr_bank_sequencer.sv
// DDR bank sequencer: decodes the target bank of each DMA descriptor and only
// moves the registered bank select once every AXI read/write burst issued on
// the current bank has completed.
// Optional per-bank burst statistics: define DMA_DDR_SEQ_STATS_EN.
module dma_ddr_bank_sequencer #(
  parameter int NUM_LOCAL_MEM_BANKS = 2,
  parameter int ADDR_WIDTH          = 64,
  parameter int SEL_WIDTH           = (NUM_LOCAL_MEM_BANKS > 2) ? $clog2(NUM_LOCAL_MEM_BANKS) : 1,
  parameter int MAX_OUTSTANDING     = 64
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 desc_valid,
  output logic                                 desc_ready,
  input  dma_pkg::t_dma_descriptor             descriptor,
  input  logic                                 ar_fire,
  input  logic                                 r_last_fire,
  input  logic                                 aw_fire,
  input  logic                                 b_fire,
  output logic [SEL_WIDTH:0]                   channel_select,
  output logic                                 ar_allow,
  output logic                                 aw_allow,
  output logic                                 busy,
  output logic                                 bad_desc,
  output logic                                 proto_err,
  output logic [NUM_LOCAL_MEM_BANKS-1:0][31:0] stat_rd_bursts,
  output logic [NUM_LOCAL_MEM_BANKS-1:0][31:0] stat_wr_bursts
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [CNT_W-1:0]   MAX_OUT_C   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [SEL_WIDTH:0] NUM_BANKS_C = (SEL_WIDTH + 1)'(NUM_LOCAL_MEM_BANKS);
  localparam logic [SEL_WIDTH:0] SEL_NONE    = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_SWITCH = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [SEL_WIDTH:0]   sel_q, sel_d;
  logic [SEL_WIDTH:0]   next_q, next_d;
  logic [CNT_W-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic                 rd_under, wr_under;
  logic                 busy_q, bad_q, bad_d, perr_q;

  logic [SEL_WIDTH-1:0] tgt;
  logic [SEL_WIDTH:0]   tgt_ext;
  logic                 mode_ok, desc_ok, desc_fire;

  // Only the bank-select bits of the addresses matter; fold the rest here.
  logic unused_desc_bits;
  assign unused_desc_bits = ^descriptor;

  assign desc_ready = (state_q == S_IDLE) || (state_q == S_ACTIVE);
  assign desc_fire  = desc_valid && desc_ready;

  // Gate new bursts only while a bank is settled; W data is never gated.
  assign ar_allow = (state_q == S_ACTIVE) && (rd_q < MAX_OUT_C);
  assign aw_allow = (state_q == S_ACTIVE) && (wr_q < MAX_OUT_C);

  assign channel_select = sel_q;
  assign busy           = busy_q;
  assign bad_desc       = bad_q;
  assign proto_err      = perr_q;

  // Target bank decode: reads hit the source side, writes the destination side.
  always_comb begin
    tgt     = '0;
    mode_ok = 1'b0;
    case (descriptor.mode)
      dma_pkg::DDR_TO_HOST: begin
        tgt     = descriptor.src_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
        mode_ok = 1'b1;
      end
      dma_pkg::HOST_TO_DDR: begin
        tgt     = descriptor.dest_addr[ADDR_WIDTH-1 -: SEL_WIDTH];
        mode_ok = 1'b1;
      end
      default: begin
        tgt     = '0;
        mode_ok = 1'b0;
      end
    endcase
    tgt_ext = {1'b0, tgt};
    desc_ok = mode_ok && (tgt_ext < NUM_BANKS_C);
  end

  // Outstanding-burst counters; a lone completion at zero is a protocol error.
  always_comb begin
    rd_d     = rd_q;
    rd_under = 1'b0;
    if (ar_fire && !r_last_fire) begin
      rd_d = rd_q + CNT_W'(1);
    end else if (!ar_fire && r_last_fire) begin
      if (rd_q == '0) rd_under = 1'b1;
      else            rd_d     = rd_q - CNT_W'(1);
    end

    wr_d     = wr_q;
    wr_under = 1'b0;
    if (aw_fire && !b_fire) begin
      wr_d = wr_q + CNT_W'(1);
    end else if (!aw_fire && b_fire) begin
      if (wr_q == '0) wr_under = 1'b1;
      else            wr_d     = wr_q - CNT_W'(1);
    end
  end

  // Bank-switch FSM; DRAIN exit looks at post-update counters so the last
  // completion edge moves straight on.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    next_d  = next_q;
    bad_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (desc_fire) begin
          if (desc_ok) begin
            state_d = S_SWITCH;
            sel_d   = tgt_ext;
            next_d  = tgt_ext;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        if (desc_fire) begin
          if (desc_ok && (tgt_ext == sel_q)) begin
            state_d = S_ACTIVE;
          end else if (desc_ok) begin
            state_d = S_DRAIN;
            next_d  = tgt_ext;
          end else begin
            state_d = S_DRAIN;
            next_d  = SEL_NONE;
            bad_d   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if ((rd_d == '0) && (wr_d == '0)) begin
          if (next_q != SEL_NONE) begin
            state_d = S_SWITCH;
            sel_d   = next_q;
          end else begin
            state_d = S_IDLE;
            sel_d   = SEL_NONE;
          end
        end
      end
      S_SWITCH: begin
        state_d = S_ACTIVE;
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
  end

  // State, select, counters and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= SEL_NONE;
      next_q  <= SEL_NONE;
      rd_q    <= '0;
      wr_q    <= '0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      next_q  <= next_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= (state_d == S_DRAIN) || (state_d == S_SWITCH);
      bad_q   <= bad_d;
      perr_q  <= perr_q | rd_under | wr_under;
    end
  end

`ifdef DMA_DDR_SEQ_STATS_EN
  for (genvar b = 0; b < NUM_LOCAL_MEM_BANKS; b++) begin : g_stat
    logic [31:0] rd_cnt_q, wr_cnt_q;
    logic        hit;

    assign hit               = (sel_q == (SEL_WIDTH + 1)'(b));
    assign stat_rd_bursts[b] = rd_cnt_q;
    assign stat_wr_bursts[b] = wr_cnt_q;

    // Completed bursts attributed to the bank selected while they finish.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_cnt_q <= '0;
        wr_cnt_q <= '0;
      end else begin
        if (hit && r_last_fire) rd_cnt_q <= rd_cnt_q + 32'd1;
        if (hit && b_fire)      wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end
`else
  assign stat_rd_bursts = '0;
  assign stat_wr_bursts = '0;
`endif

endmodule

// File: tb/tb_dma_ddr_bank_sequencer.sv
// Randomized self-checking bench for dma_ddr_bank_sequencer against a
// cycle-level behavioural model of the bank-switch rules.
module tb_dma_ddr_bank_sequencer;

  localparam int NB   = 2;
  localparam int SW   = 1;
  localparam int MAXO = 64;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      desc_valid;
  logic                      desc_ready;
  dma_pkg::t_dma_descriptor  descriptor;
  logic                      ar_fire, r_last_fire, aw_fire, b_fire;
  logic [SW:0]               channel_select;
  logic                      ar_allow, aw_allow, busy, bad_desc, proto_err;
  logic [NB-1:0][31:0]       stat_rd_bursts, stat_wr_bursts;

  dma_ddr_bank_sequencer #(
    .NUM_LOCAL_MEM_BANKS(NB), .ADDR_WIDTH(64), .SEL_WIDTH(SW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .descriptor(descriptor),
    .ar_fire(ar_fire), .r_last_fire(r_last_fire), .aw_fire(aw_fire), .b_fire(b_fire),
    .channel_select(channel_select), .ar_allow(ar_allow), .aw_allow(aw_allow),
    .busy(busy), .bad_desc(bad_desc), .proto_err(proto_err),
    .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts)
  );

  always #5 clk = ~clk;

  // ---- reference model: bank held, pending bank, phase flags, burst counts
  int          m_sel, m_next, m_rd, m_wr;   // -1 means "no bank"
  bit          m_active, m_drain, m_switch;
  bit          m_perr, m_bad;
  logic [31:0] m_srd [NB];
  logic [31:0] m_swr [NB];

  int nchk = 0;
  int nerr = 0;

  // directed stimulus staging
  bit d_dv, d_ar, d_rl, d_aw, d_b, d_msb;
  int d_mode;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_sel = -1; m_next = -1; m_rd = 0; m_wr = 0;
    m_active = 0; m_drain = 0; m_switch = 0; m_perr = 0; m_bad = 0;
    for (int i = 0; i < NB; i++) begin m_srd[i] = '0; m_swr[i] = '0; end
  endfunction

  function automatic bit m_ready();
    return !(m_drain || m_switch);
  endfunction

  function automatic bit m_ar_ok();
    return m_active && (m_rd < MAXO);
  endfunction

  function automatic bit m_aw_ok();
    return m_active && (m_wr < MAXO);
  endfunction

  task automatic check_outs();
    logic [SW:0] es;
    es = (m_sel < 0) ? '1 : (SW+1)'(m_sel);
    chk("channel_select", 64'(channel_select), 64'(es));
    chk("desc_ready", 64'(desc_ready), 64'(m_ready()));
    chk("ar_allow", 64'(ar_allow), 64'(m_ar_ok()));
    chk("aw_allow", 64'(aw_allow), 64'(m_aw_ok()));
    chk("busy", 64'(busy), 64'(m_drain || m_switch));
    chk("bad_desc", 64'(bad_desc), 64'(m_bad));
    chk("proto_err", 64'(proto_err), 64'(m_perr));
    for (int i = 0; i < NB; i++) begin
`ifdef DMA_DDR_SEQ_STATS_EN
      chk("stat_rd", 64'(stat_rd_bursts[i]), 64'(m_srd[i]));
      chk("stat_wr", 64'(stat_wr_bursts[i]), 64'(m_swr[i]));
`else
      chk("stat_rd", 64'(stat_rd_bursts[i]), 64'd0);
      chk("stat_wr", 64'(stat_wr_bursts[i]), 64'd0);
`endif
    end
  endtask

  // Advance the model by one clock edge using the inputs just sampled.
  function automatic void m_step();
    bit fire, ok;
    int rn, wn, tgt, md;
    fire = desc_valid && m_ready();
    rn = m_rd; wn = m_wr;
    if (ar_fire && !r_last_fire) rn++;
    else if (r_last_fire && !ar_fire) begin if (m_rd == 0) m_perr = 1; else rn--; end
    if (aw_fire && !b_fire) wn++;
    else if (b_fire && !aw_fire) begin if (m_wr == 0) m_perr = 1; else wn--; end
    if (m_sel >= 0) begin
      if (r_last_fire) m_srd[m_sel] = m_srd[m_sel] + 32'd1;
      if (b_fire)      m_swr[m_sel] = m_swr[m_sel] + 32'd1;
    end
    md  = int'(descriptor.mode);
    tgt = (md == 0) ? int'(descriptor.src_addr >> (64 - SW)) : int'(descriptor.dest_addr >> (64 - SW));
    ok  = ((md == 0) || (md == 1)) && (tgt < NB);
    m_bad = 0;
    if (m_switch) begin
      m_switch = 0; m_active = 1;
    end else if (m_drain) begin
      if (rn == 0 && wn == 0) begin
        m_drain = 0;
        if (m_next >= 0) begin m_switch = 1; m_sel = m_next; end
        else m_sel = -1;
      end
    end else if (m_active) begin
      if (fire) begin
        if (!ok) begin m_active = 0; m_drain = 1; m_next = -1; m_bad = 1; end
        else if (tgt != m_sel) begin m_active = 0; m_drain = 1; m_next = tgt; end
      end
    end else begin
      if (fire) begin
        if (ok) begin m_switch = 1; m_sel = tgt; m_next = tgt; end
        else m_bad = 1;
      end
    end
    m_rd = rn; m_wr = wn;
  endfunction

  task automatic set_desc(input bit dv, input int mode, input bit msb);
    logic [1:0] mb;
    mb = 2'(mode);
    desc_valid = dv;
    descriptor.mode      = dma_pkg::t_dma_mode'(mb);
    descriptor.src_addr  = {msb, 31'($urandom), 32'($urandom)};
    descriptor.dest_addr = {~msb, 31'($urandom), 32'($urandom)};
    // the non-target side address gets the opposite MSB so a wrong decode shows
    if (mb == 2'd1) begin
      descriptor.dest_addr[63] = msb;
      descriptor.src_addr[63]  = ~msb;
    end
  endtask

  // phase: -1 directed, 0 random traffic, 1 fill (no completions), 2 underflow
  task automatic step(input int phase);
    int r;
    @(negedge clk);
    check_outs();
    if (phase < 0) begin
      set_desc(d_dv, d_mode, d_msb);
      ar_fire = d_ar; r_last_fire = d_rl; aw_fire = d_aw; b_fire = d_b;
    end else begin
      r = $urandom_range(0, 9);
      set_desc((phase == 0) && ($urandom_range(0, 7) == 0),
               (r < 4) ? 0 : (r < 8) ? 1 : $urandom_range(2, 3), 1'($urandom));
      case (phase)
        0: begin
          ar_fire     = m_ar_ok() && ($urandom_range(0, 1) == 1);
          aw_fire     = m_aw_ok() && ($urandom_range(0, 1) == 1);
          r_last_fire = (m_rd > 0) && ($urandom_range(0, 2) == 0);
          b_fire      = (m_wr > 0) && ($urandom_range(0, 2) == 0);
        end
        1: begin
          ar_fire = m_ar_ok(); aw_fire = m_aw_ok(); r_last_fire = 0; b_fire = 0;
        end
        default: begin
          ar_fire = 0; aw_fire = 0; r_last_fire = 1; b_fire = 1'($urandom);
        end
      endcase
    end
    @(posedge clk);
    m_step();
  endtask

  task automatic drv(input bit dv, input int mode, input bit msb,
                     input bit ar, input bit rl, input bit aw, input bit b);
    d_dv = dv; d_mode = mode; d_msb = msb; d_ar = ar; d_rl = rl; d_aw = aw; d_b = b;
    step(-1);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    desc_valid = 0; ar_fire = 0; r_last_fire = 0; aw_fire = 0; b_fire = 0;
    set_desc(0, 0, 0);
    m_reset();
    #12;
    check_outs();
    @(negedge clk); reset_n = 1'b1;

    // HOST_TO_DDR to bank 1 from IDLE: select at T+1, allows at T+2
    drv(1, 1, 1, 0, 0, 0, 0);
    idle_n(3);
    chk("idle_accept_sel", 64'(channel_select), 64'd1);

    // move to bank 0, three reads out, then request bank 1
    drv(1, 0, 0, 0, 0, 0, 0);
    idle_n(4);
    drv(0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0, 0);
    drv(1, 0, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("drain_hold_sel", 64'(channel_select), 64'd0);
    drv(0, 0, 0, 0, 1, 0, 0);
    idle_n(3);

    // simultaneous aw/b with two writes outstanding, then fill to the limit
    drv(0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 70; i++) step(1);
    chk("aw_allow_at_max", 64'(aw_allow), 64'd0);
    for (int i = 0; i < 200; i++) step(0);

    // invalid mode while ACTIVE: drain back to IDLE with no bank
    guard = 0;
    while (!m_active && guard < 500) begin
      if (!m_drain && !m_switch && !m_active) drv(1, 1, 0, 0, 0, 0, 0);
      else step(0);
      guard++;
    end
    chk("reach_active", 64'(m_active), 64'd1);
    drv(1, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      d_dv = 0; d_mode = 0; d_msb = 0; d_ar = 0; d_aw = 0;
      d_rl = (m_rd > 0); d_b = (m_wr > 0);
      step(-1);
    end
    chk("bad_to_idle_sel", 64'(channel_select), 64'(2'b11));

    // long randomized run
    for (int i = 0; i < 2500; i++) step(0);

    // completions with nothing outstanding: sticky protocol error
    for (int i = 0; i < 200 && (m_rd > 0 || m_wr > 0 || m_active); i++) begin
      d_dv = 0; d_mode = 0; d_msb = 0; d_ar = 0; d_aw = 0;
      d_rl = (m_rd > 0); d_b = (m_wr > 0);
      step(-1);
    end
    for (int i = 0; i < 4; i++) step(2);
    idle_n(3);
    chk("proto_err_sticky", 64'(proto_err), 64'd1);

    // async reset while draining
    guard = 0;
    while (!m_drain && guard < 3000) begin step(0); guard++; end
    chk("reach_drain", 64'(m_drain), 64'd1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check_outs();
    desc_valid = 0; ar_fire = 0; r_last_fire = 0; aw_fire = 0; b_fire = 0;
    @(negedge clk);
    check_outs();
    reset_n = 1'b1;
    for (int i = 0; i < 500; i++) step(0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
